// File: rtl/dmm_mem_pkg.sv
// Shared memory constants and helpers for the DMM FPGA sample-buffer path.
package dmm_mem_pkg;

    localparam int unsigned DMM_DATA_W   = 8;
    localparam int unsigned DMM_ADDR_W   = 9;
    localparam int unsigned DMM_AF_LEVEL = 496;
    localparam int unsigned DMM_AE_LEVEL = 16;

    // Occupancy must represent 0..2**addr_w inclusive, hence one extra bit.
    function automatic int unsigned count_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/ram_dp_param.sv
// Parametrised simple dual-port RAM: one write port, one registered read port, single clock.
module ram_dp_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              CLK,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RADDR,
    output logic [DATA_W-1:0] RDATA
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array or read register so the block maps onto EBRs.
    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[WADDR] <= WDATA;
        end
        if (RE) begin
            RDATA <= mem[RADDR];
        end
    end

endmodule

// File: rtl/fifo_sync_ram.sv
// Single-clock FIFO over ram_dp_param with occupancy, level flags and sticky error flags.
module fifo_sync_ram
    import dmm_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = DMM_DATA_W,
    parameter int unsigned ADDR_W   = DMM_ADDR_W,
    parameter int unsigned AF_LEVEL = DMM_AF_LEVEL,
    parameter int unsigned AE_LEVEL = DMM_AE_LEVEL
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              RE,
    output logic [DATA_W-1:0] RDATA,
    output logic              RVALID,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVF,
    output logic              UDF,
    input  logic              CLR_ERR
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;
    localparam int unsigned CNT_W = count_w(ADDR_W);

    if (AF_LEVEL > DEPTH) begin : g_af_chk
        $error("fifo_sync_ram: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= AF_LEVEL) begin : g_ae_chk
        $error("fifo_sync_ram: AE_LEVEL must be below AF_LEVEL");
    end

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [DATA_W-1:0] ram_q;
    logic              rd_seen;
    logic              wr_ok;
    logic              rd_ok;
    logic [CNT_W-1:0]  cnt_nxt;

    // Acceptance is gated by the registered flags of the current cycle.
    always_comb begin
        wr_ok   = WE & ~FULL;
        rd_ok   = RE & ~EMPTY;
        cnt_nxt = COUNT;
        if (wr_ok && !rd_ok) begin
            cnt_nxt = COUNT + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            cnt_nxt = COUNT - CNT_W'(1);
        end
    end

    ram_dp_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK   (CLK),
        .WE    (wr_ok),
        .WADDR (wptr),
        .WDATA (WDATA),
        .RE    (rd_ok),
        .RADDR (rptr),
        .RDATA (ram_q)
    );

    // Flags are derived from the next count so they line up with COUNT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr         <= '0;
            rptr         <= '0;
            COUNT        <= '0;
            RVALID       <= 1'b0;
            rd_seen      <= 1'b0;
            FULL         <= 1'b0;
            EMPTY        <= 1'b1;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            OVF          <= 1'b0;
            UDF          <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rptr    <= rptr + ADDR_W'(1);
                rd_seen <= 1'b1;
            end
            RVALID       <= rd_ok;
            COUNT        <= cnt_nxt;
            FULL         <= (cnt_nxt == CNT_W'(DEPTH));
            EMPTY        <= (cnt_nxt == '0);
            ALMOST_FULL  <= (cnt_nxt >= CNT_W'(AF_LEVEL));
            ALMOST_EMPTY <= (cnt_nxt <= CNT_W'(AE_LEVEL));
            // A new error event outranks a simultaneous clear.
            if (WE && FULL) begin
                OVF <= 1'b1;
            end else if (CLR_ERR) begin
                OVF <= 1'b0;
            end
            if (RE && EMPTY) begin
                UDF <= 1'b1;
            end else if (CLR_ERR) begin
                UDF <= 1'b0;
            end
        end
    end

    // The EBR read register has no reset; present zero until the first pop after reset.
    always_comb begin
        RDATA = rd_seen ? ram_q : '0;
    end

endmodule

// File: tb/tb_fifo_sync_ram.sv
// Self-checking bench for fifo_sync_ram: queue model plus read scoreboard.
module tb_fifo_sync_ram;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WE = 1'b0;
    logic [7:0] WDATA = '0;
    logic       RE = 1'b0;
    logic       CLR_ERR = 1'b0;
    logic [7:0] RDATA;
    logic       RVALID;
    logic       FULL;
    logic       EMPTY;
    logic       ALMOST_FULL;
    logic       ALMOST_EMPTY;
    logic [9:0] COUNT;
    logic       OVF;
    logic       UDF;

    int checks = 0;
    int failures = 0;

    logic [7:0] mdl [$];
    logic [7:0] sb  [$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic       m_rv  = 1'b0;

    fifo_sync_ram dut (
        .CLK          (CLK),
        .RST          (RST),
        .WE           (WE),
        .WDATA        (WDATA),
        .RE           (RE),
        .RDATA        (RDATA),
        .RVALID       (RVALID),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .COUNT        (COUNT),
        .OVF          (OVF),
        .UDF          (UDF),
        .CLR_ERR      (CLR_ERR)
    );

    always #5 CLK = ~CLK;

    // One clock of stimulus; the model advances and accepted reads go to the scoreboard.
    task automatic step(input logic we, input logic [7:0] wd, input logic re,
                        input logic clr, input logic rst);
        logic mfull, mempty, wok, rok;
        WE = we; WDATA = wd; RE = re; CLR_ERR = clr; RST = rst;
        mfull  = (mdl.size() == 512);
        mempty = (mdl.size() == 0);
        wok    = we && !mfull;
        rok    = re && !mempty;
        @(posedge CLK);
        #1;
        if (rst) begin
            mdl.delete();
            sb.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rv  = 1'b0;
        end else begin
            m_rv = rok;
            if (rok) sb.push_back(mdl.pop_front());
            if (wok) mdl.push_back(wd);
            m_ovf = (we && mfull)  ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_udf = (re && mempty) ? 1'b1 : (clr ? 1'b0 : m_udf);
        end
        WE = 1'b0; RE = 1'b0; CLR_ERR = 1'b0; RST = 1'b0;
    endtask

    task automatic test_reset();
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        checks++;
        if ({EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL, RVALID, OVF, UDF} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 1100000",
                     {EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL, RVALID, OVF, UDF});
        end
        checks++;
        if (COUNT !== 10'd0 || RDATA !== 8'h00) begin
            failures++;
            $display("FAIL reset_count_rdata: count=%0d rdata=%h expected 0/00", COUNT, RDATA);
        end
        step(0, 8'h00, 1, 0, 0);
        checks++;
        if (UDF !== 1'b1 || RVALID !== 1'b0 || COUNT !== 10'd0) begin
            failures++;
            $display("FAIL underflow_idle: udf=%b rvalid=%b count=%0d expected 1/0/0", UDF, RVALID, COUNT);
        end
        step(0, 8'h00, 0, 1, 0);
        checks++;
        if (UDF !== 1'b0) begin
            failures++;
            $display("FAIL clr_err_udf: udf=%b expected 0", UDF);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        for (int i = 1; i <= 32; i++) begin
            step(1, 8'(i), 0, 0, 0);
            checks++;
            if (COUNT !== 10'(mdl.size()) || ALMOST_EMPTY !== (mdl.size() <= 16) || EMPTY !== 1'b0) begin
                failures++;
                $display("FAIL basic_write[%0d]: count=%0d ae=%b empty=%b expected %0d/%b/0",
                         i, COUNT, ALMOST_EMPTY, EMPTY, mdl.size(), mdl.size() <= 16);
            end
        end
        for (int i = 1; i <= 32; i++) begin
            step(0, 8'h00, 1, 0, 0);
            exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            checks++;
            if (RVALID !== 1'b1 || RDATA !== exp || exp !== 8'(i)) begin
                failures++;
                $display("FAIL basic_read[%0d]: rvalid=%b rdata=%h expected 1/%h", i, RVALID, RDATA, 8'(i));
            end
            checks++;
            if (COUNT !== 10'(mdl.size()) || ALMOST_EMPTY !== (mdl.size() <= 16)) begin
                failures++;
                $display("FAIL basic_drain_flags[%0d]: count=%0d ae=%b expected %0d/%b",
                         i, COUNT, ALMOST_EMPTY, mdl.size(), mdl.size() <= 16);
            end
        end
        step(0, 8'h00, 0, 0, 0);
        checks++;
        if (EMPTY !== 1'b1 || RVALID !== 1'b0 || RDATA !== 8'h20) begin
            failures++;
            $display("FAIL basic_end: empty=%b rvalid=%b rdata=%h expected 1/0/20", EMPTY, RVALID, RDATA);
        end
    endtask

    task automatic test_fill();
        logic [7:0] exp;
        for (int i = 0; i < 512; i++) begin
            step(1, 8'(i), 0, 0, 0);
            checks++;
            if (COUNT !== 10'(mdl.size()) || ALMOST_FULL !== (mdl.size() >= 496) ||
                FULL !== (mdl.size() == 512)) begin
                failures++;
                $display("FAIL fill[%0d]: count=%0d af=%b full=%b expected %0d/%b/%b",
                         i, COUNT, ALMOST_FULL, FULL, mdl.size(), mdl.size() >= 496, mdl.size() == 512);
            end
        end
        step(1, 8'hEE, 0, 0, 0);
        checks++;
        if (OVF !== 1'b1 || COUNT !== 10'd512 || FULL !== 1'b1) begin
            failures++;
            $display("FAIL overflow: ovf=%b count=%0d full=%b expected 1/512/1", OVF, COUNT, FULL);
        end
        for (int i = 0; i < 512; i++) begin
            step(0, 8'h00, 1, 0, 0);
            exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            checks++;
            if (RVALID !== 1'b1 || RDATA !== exp || exp !== 8'(i)) begin
                failures++;
                $display("FAIL drain[%0d]: rvalid=%b rdata=%h expected 1/%h", i, RVALID, RDATA, 8'(i));
            end
        end
        step(0, 8'h00, 0, 1, 0);
        checks++;
        if (OVF !== m_ovf || EMPTY !== 1'b1 || COUNT !== 10'd0) begin
            failures++;
            $display("FAIL fill_end: ovf=%b empty=%b count=%0d expected %b/1/0", OVF, EMPTY, COUNT, m_ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 500; i++) begin
            step(1, 8'(i), 0, 0, 0);
            step(0, 8'h00, 1, 0, 0);
            if (RVALID === 1'b1 && sb.size() != 0) void'(sb.pop_front());
        end
        for (int i = 0; i < 100; i++) step(1, 8'(i * 3), 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            step(1, 8'(i + 7), 1, 0, 0);
            exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            checks++;
            if (COUNT !== 10'd100 || RVALID !== 1'b1 || RDATA !== exp) begin
                failures++;
                $display("FAIL simul[%0d]: count=%0d rvalid=%b rdata=%h expected 100/1/%h",
                         i, COUNT, RVALID, RDATA, exp);
            end
        end
        for (int i = 0; i < 100; i++) begin
            step(0, 8'h00, 1, 0, 0);
            exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            checks++;
            if (RVALID !== 1'b1 || RDATA !== exp) begin
                failures++;
                $display("FAIL simul_drain[%0d]: rvalid=%b rdata=%h expected 1/%h", i, RVALID, RDATA, exp);
            end
        end
        checks++;
        if (EMPTY !== 1'b1 || COUNT !== 10'd0 || OVF !== 1'b0 || UDF !== 1'b0) begin
            failures++;
            $display("FAIL simul_end: empty=%b count=%0d ovf=%b udf=%b expected 1/0/0/0", EMPTY, COUNT, OVF, UDF);
        end
    endtask

    task automatic test_empty_simul();
        logic [7:0] exp;
        step(1, 8'h5C, 1, 0, 0);
        checks++;
        if (COUNT !== 10'd1 || UDF !== 1'b1 || RVALID !== 1'b0 || EMPTY !== 1'b0) begin
            failures++;
            $display("FAIL empty_simul: count=%0d udf=%b rvalid=%b empty=%b expected 1/1/0/0",
                     COUNT, UDF, RVALID, EMPTY);
        end
        step(0, 8'h00, 1, 0, 0);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== exp || exp !== 8'h5C) begin
            failures++;
            $display("FAIL empty_simul_read: rvalid=%b rdata=%h expected 1/5c", RVALID, RDATA);
        end
        // Clear together with a fresh underflow: the error must stay set.
        step(0, 8'h00, 1, 1, 0);
        checks++;
        if (UDF !== 1'b1 || UDF !== m_udf) begin
            failures++;
            $display("FAIL clr_vs_err: udf=%b expected 1", UDF);
        end
        step(0, 8'h00, 0, 1, 0);
        checks++;
        if (UDF !== 1'b0) begin
            failures++;
            $display("FAIL clr_udf: udf=%b expected 0", UDF);
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] exp;
        for (int i = 0; i < 200; i++) step(1, 8'(i) ^ 8'h3C, 0, 0, 0);
        step(1, 8'h11, 1, 0, 1);
        checks++;
        if (COUNT !== 10'd0 || EMPTY !== 1'b1 || RVALID !== 1'b0 || RDATA !== 8'h00 || ALMOST_FULL !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: count=%0d empty=%b rvalid=%b rdata=%h af=%b expected 0/1/0/00/0",
                     COUNT, EMPTY, RVALID, RDATA, ALMOST_FULL);
        end
        step(1, 8'hA5, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== exp || exp !== 8'hA5 || COUNT !== 10'd0) begin
            failures++;
            $display("FAIL post_reset_rw: rvalid=%b rdata=%h count=%0d expected 1/a5/0", RVALID, RDATA, COUNT);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_empty_simul();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
